// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin arbiter for a pipelined Wishbone slave bus.
// Holds the grant for a whole CYC, tracks outstanding requests and aborts stuck cycles.
module wb_rr_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LGDEPTH = 4,
  parameter int TIMEOUT = 64
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_a_cyc,
  input  logic            i_a_stb,
  input  logic            i_a_we,
  input  logic [AW-1:0]   i_a_addr,
  input  logic [DW-1:0]   i_a_data,
  input  logic [DW/8-1:0] i_a_sel,
  output logic            o_a_ack,
  output logic            o_a_stall,
  output logic            o_a_err,
  input  logic            i_b_cyc,
  input  logic            i_b_stb,
  input  logic            i_b_we,
  input  logic [AW-1:0]   i_b_addr,
  input  logic [DW-1:0]   i_b_data,
  input  logic [DW/8-1:0] i_b_sel,
  output logic            o_b_ack,
  output logic            o_b_stall,
  output logic            o_b_err,
  output logic [DW-1:0]   o_rdata,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_ack,
  input  logic            i_wb_stall,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_idata,
  output logic [1:0]      o_owner
);

  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B, ABORT} state_t;

  state_t             state;
  logic               last_b;
  logic               abort_b;
  logic               abort_first;
  logic [LGDEPTH-1:0] outstanding;
  logic [WDW-1:0]     wd;

  logic            granted, sel_b, full, m_cyc, m_stb, waiting, timeout;
  logic            accept, retire;

  assign granted = (state == GRANT_A) || (state == GRANT_B);
  assign sel_b   = (state == GRANT_B);
  assign full    = &outstanding;
  assign m_cyc   = sel_b ? i_b_cyc : i_a_cyc;
  assign m_stb   = sel_b ? i_b_stb : i_a_stb;
  assign o_rdata = i_wb_idata;

  assign waiting = granted && (outstanding != '0) && !i_wb_ack && !i_wb_err;
  assign timeout = (TIMEOUT > 0) && waiting && (wd == WDW'(TIMEOUT - 1));
  assign accept  = o_wb_stb && !i_wb_stall;
  assign retire  = i_wb_ack || i_wb_err;

  always_comb begin
    o_wb_cyc  = 1'b0;
    o_wb_stb  = 1'b0;
    o_wb_we   = 1'b0;
    o_wb_addr = '0;
    o_wb_data = '0;
    o_wb_sel  = '0;
    o_a_ack   = 1'b0;
    o_a_err   = 1'b0;
    o_a_stall = 1'b1;
    o_b_ack   = 1'b0;
    o_b_err   = 1'b0;
    o_b_stall = 1'b1;
    o_owner   = 2'b00;
    if (granted) begin
      o_wb_cyc  = m_cyc;
      o_wb_stb  = m_stb && !full;
      o_wb_we   = sel_b ? i_b_we   : i_a_we;
      o_wb_addr = sel_b ? i_b_addr : i_a_addr;
      o_wb_data = sel_b ? i_b_data : i_a_data;
      o_wb_sel  = sel_b ? i_b_sel  : i_a_sel;
      o_owner   = {1'b1, sel_b};
      if (sel_b) begin
        o_b_stall = i_wb_stall || full;
        o_b_ack   = i_wb_ack;
        o_b_err   = i_wb_err;
      end else begin
        o_a_stall = i_wb_stall || full;
        o_a_ack   = i_wb_ack;
        o_a_err   = i_wb_err;
      end
    end else if (state == ABORT) begin
      // Bus stays reserved for the aborted master until it lets go of CYC.
      o_owner = {1'b1, abort_b};
      if (abort_b) o_b_err = abort_first;
      else         o_a_err = abort_first;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      last_b      <= 1'b1;
      abort_b     <= 1'b0;
      abort_first <= 1'b0;
      outstanding <= '0;
      wd          <= '0;
    end else begin
      abort_first <= 1'b0;
      wd          <= waiting ? wd + 1'b1 : '0;

      if (!o_wb_cyc)
        outstanding <= '0;
      else if (accept && !retire)
        outstanding <= outstanding + 1'b1;
      else if (retire && !accept && (outstanding != '0))
        outstanding <= outstanding - 1'b1;

      case (state)
        IDLE: begin
          if (i_a_cyc && (!i_b_cyc || last_b)) state <= GRANT_A;
          else if (i_b_cyc)                   state <= GRANT_B;
        end
        GRANT_A, GRANT_B: begin
          if (!m_cyc) begin
            state  <= IDLE;
            last_b <= sel_b;
          end else if (timeout) begin
            state       <= ABORT;
            abort_b     <= sel_b;
            abort_first <= 1'b1;
          end
        end
        ABORT: begin
          if (!(abort_b ? i_b_cyc : i_a_cyc)) begin
            state  <= IDLE;
            last_b <= abort_b;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Randomized bench for wb_rr_arbiter against a transaction-level owner/in-flight model.
module tb_wb_rr_arbiter;

  localparam int AW      = 16;
  localparam int DW      = 32;
  localparam int LGDEPTH = 2;
  localparam int TIMEOUT = 8;
  localparam int MAXQ    = (1 << LGDEPTH) - 1;
  localparam int NCYC    = 4000;

  logic            i_clk = 1'b0;
  logic            i_reset_n;
  logic            m_cyc [2];
  logic            m_stb [2];
  logic            m_we  [2];
  logic [AW-1:0]   m_addr[2];
  logic [DW-1:0]   m_data[2];
  logic [DW/8-1:0] m_sel [2];
  logic            o_a_ack, o_a_stall, o_a_err, o_b_ack, o_b_stall, o_b_err;
  logic [DW-1:0]   o_rdata, o_wb_data;
  logic            o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0]   o_wb_addr;
  logic [DW/8-1:0] o_wb_sel;
  logic            i_wb_ack, i_wb_stall, i_wb_err;
  logic [DW-1:0]   i_wb_idata;
  logic [1:0]      o_owner;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  // Model: owner -1 = nobody, 0 = A, 1 = B.
  int owner, last, inflight, waited;
  bit aborting, fresh;
  int hold[2];

  always #5 i_clk = ~i_clk;

  wb_rr_arbiter #(.AW(AW), .DW(DW), .LGDEPTH(LGDEPTH), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_a_cyc(m_cyc[0]), .i_a_stb(m_stb[0]), .i_a_we(m_we[0]),
    .i_a_addr(m_addr[0]), .i_a_data(m_data[0]), .i_a_sel(m_sel[0]),
    .o_a_ack(o_a_ack), .o_a_stall(o_a_stall), .o_a_err(o_a_err),
    .i_b_cyc(m_cyc[1]), .i_b_stb(m_stb[1]), .i_b_we(m_we[1]),
    .i_b_addr(m_addr[1]), .i_b_data(m_data[1]), .i_b_sel(m_sel[1]),
    .o_b_ack(o_b_ack), .o_b_stall(o_b_stall), .o_b_err(o_b_err),
    .o_rdata(o_rdata), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err),
    .i_wb_idata(i_wb_idata), .o_owner(o_owner)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc_n, got, exp);
    end
  endtask

  task automatic check_outputs();
    bit g;
    bit full;
    logic e_ack[2], e_err[2], e_stall[2];
    g    = (owner >= 0) && !aborting;
    full = (inflight == MAXQ);
    for (int m = 0; m < 2; m++) begin
      e_ack[m] = 1'b0; e_err[m] = 1'b0; e_stall[m] = 1'b1;
    end
    if (g) begin
      e_ack[owner]   = i_wb_ack;
      e_err[owner]   = i_wb_err;
      e_stall[owner] = i_wb_stall || full;
    end else if (aborting) begin
      e_err[owner] = fresh;
    end
    check_eq("wb_cyc",  o_wb_cyc,  g ? m_cyc[owner] : 1'b0);
    check_eq("wb_stb",  o_wb_stb,  g ? (m_stb[owner] && !full) : 1'b0);
    check_eq("wb_we",   o_wb_we,   g ? m_we[owner]   : 1'b0);
    check_eq("wb_addr", o_wb_addr, g ? m_addr[owner] : '0);
    check_eq("wb_data", o_wb_data, g ? m_data[owner] : '0);
    check_eq("wb_sel",  o_wb_sel,  g ? m_sel[owner]  : '0);
    check_eq("a_ack",   o_a_ack,   e_ack[0]);
    check_eq("a_err",   o_a_err,   e_err[0]);
    check_eq("a_stall", o_a_stall, e_stall[0]);
    check_eq("b_ack",   o_b_ack,   e_ack[1]);
    check_eq("b_err",   o_b_err,   e_err[1]);
    check_eq("b_stall", o_b_stall, e_stall[1]);
    check_eq("owner",   o_owner,   (owner < 0) ? 2'b00 : {1'b1, owner[0]});
    check_eq("rdata",   o_rdata,   i_wb_idata);
  endtask

  task automatic model_step();
    int acc;
    int done;
    if (!i_reset_n) begin
      owner = -1; last = 1; aborting = 0; fresh = 0; inflight = 0; waited = 0;
    end else if (owner < 0) begin
      if (m_cyc[0] && m_cyc[1]) owner = 1 - last;
      else if (m_cyc[0])        owner = 0;
      else if (m_cyc[1])        owner = 1;
    end else if (aborting) begin
      fresh = 0;
      if (!m_cyc[owner]) begin
        last = owner; owner = -1; aborting = 0;
      end
    end else begin
      acc  = (m_stb[owner] && inflight < MAXQ && !i_wb_stall) ? 1 : 0;
      done = (i_wb_ack || i_wb_err) ? 1 : 0;
      waited = (inflight > 0 && done == 0) ? waited + 1 : 0;
      inflight = inflight + acc - done;
      if (inflight < 0) inflight = 0;
      if (!m_cyc[owner]) begin
        last = owner; owner = -1; inflight = 0; waited = 0;
      end else if (TIMEOUT > 0 && waited == TIMEOUT) begin
        aborting = 1; fresh = 1; inflight = 0; waited = 0;
      end
    end
  endtask

  task automatic drive_random(input int c);
    int r;
    bit dead;
    i_reset_n = (c < 3) ? 1'b0 : (($urandom % 300) != 0);
    for (int m = 0; m < 2; m++) begin
      if (hold[m] == 0) begin
        m_cyc[m] = ($urandom % 3) != 0;
        hold[m]  = $urandom_range(1, 14);
      end else begin
        hold[m]--;
      end
      m_stb[m]  = m_cyc[m] && (($urandom % 5) < 3);
      m_we[m]   = $urandom % 2;
      m_addr[m] = AW'($urandom);
      m_data[m] = DW'($urandom);
      m_sel[m]  = (DW/8)'($urandom);
    end
    dead       = ((c / 80) % 3) == 2;
    r          = $urandom % 20;
    i_wb_stall = !dead && (($urandom % 4) == 0);
    i_wb_ack   = !dead && (r < 8);
    i_wb_err   = !dead && (r == 8);
    i_wb_idata = DW'($urandom);
  endtask

  initial begin
    i_reset_n = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
      m_addr[m] = '0; m_data[m] = '0; m_sel[m] = '0; hold[m] = 0;
    end
    i_wb_ack = 1'b0; i_wb_stall = 1'b0; i_wb_err = 1'b0; i_wb_idata = '0;
    owner = -1; last = 1; aborting = 0; fresh = 0; inflight = 0; waited = 0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge i_clk);
      cyc_n = c;
      drive_random(c);
      #1;
      if (c > 0) check_outputs();
      model_step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
